// File: rtl/rename_regfile_ckpt_pkg.sv
// Shared widths and checkpoint slot layout for the rename register file.
// Slot layout, LSB first: busy vector [NUM_ARCH-1:0], then NUM_ARCH dep ids.
package rename_regfile_ckpt_pkg;
  localparam int REG_ADDR_W    = 5;
  localparam int XLEN          = 32;
  localparam int NUM_ARCH      = 32;
  localparam int ROB_WIDTH_DEF = 4;

  function automatic int ckpt_slot_w(input int rob_w);
    return NUM_ARCH * (1 + rob_w);
  endfunction
endpackage

// File: rtl/rf_ckpt_fifo.sv
// Circular FIFO of branch checkpoints (busy vector + dep ids) with
// commit-driven busy clearing inside the stored slots.
module rf_ckpt_fifo
  import rename_regfile_ckpt_pkg::*;
#(
  parameter int ROB_WIDTH  = ROB_WIDTH_DEF,
  parameter int CKPT_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          save_req,
  input  logic [NUM_ARCH-1:0]           save_busy,
  input  logic [NUM_ARCH*ROB_WIDTH-1:0] save_dep,
  input  logic                          release_req,
  input  logic                          restore_req,
  input  logic [CKPT_WIDTH-1:0]         restore_id,
  input  logic [NUM_ARCH-1:0]           commit_en,
  input  logic [NUM_ARCH*ROB_WIDTH-1:0] commit_id,
  output logic [CKPT_WIDTH-1:0]         save_id,
  output logic                          full,
  output logic                          restore_ok,
  output logic [NUM_ARCH-1:0]           rest_busy,
  output logic [NUM_ARCH*ROB_WIDTH-1:0] rest_dep
);
  localparam int NUM_CKPT = 2 ** CKPT_WIDTH;
  localparam int SLOT_W   = ckpt_slot_w(ROB_WIDTH);
  localparam logic [CKPT_WIDTH-1:0] PTR_ONE  = CKPT_WIDTH'(1);
  localparam logic [CKPT_WIDTH:0]   CNT_ONE  = (CKPT_WIDTH+1)'(1);
  localparam logic [CKPT_WIDTH:0]   CNT_FULL = (CKPT_WIDTH+1)'(NUM_CKPT);

  logic [SLOT_W-1:0]     slot_q [NUM_CKPT];
  logic [SLOT_W-1:0]     slot_d [NUM_CKPT];
  logic [CKPT_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CKPT_WIDTH:0]   count_q, count_d;
  logic [NUM_ARCH-1:0]   live_busy [NUM_CKPT];
  logic [CKPT_WIDTH-1:0] rest_off;
  logic                  save_ok, rel_ok;

  // Slot busy bits with this cycle's commits already removed.
  always_comb begin
    for (int s = 0; s < NUM_CKPT; s++) begin
      for (int r = 0; r < NUM_ARCH; r++) begin
        live_busy[s][r] = slot_q[s][r] &
          ~(commit_en[r] &&
            (slot_q[s][NUM_ARCH + r*ROB_WIDTH +: ROB_WIDTH] == commit_id[r*ROB_WIDTH +: ROB_WIDTH]));
      end
    end
  end

  assign rest_off   = restore_id - head_q;
  assign restore_ok = restore_req && ({1'b0, rest_off} < count_q);
  assign full       = (count_q == CNT_FULL);
  assign save_ok    = save_req && !full && !restore_req;
  assign rel_ok     = release_req && (count_q != '0) && !restore_ok;
  assign save_id    = tail_q;
  assign rest_busy  = live_busy[restore_id];
  assign rest_dep   = slot_q[restore_id][SLOT_W-1:NUM_ARCH];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int s = 0; s < NUM_CKPT; s++) begin
      slot_d[s] = {slot_q[s][SLOT_W-1:NUM_ARCH], live_busy[s]};
    end
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (restore_ok) begin
      // The restored slot stays live; everything younger is discarded.
      tail_d  = restore_id + PTR_ONE;
      count_d = {1'b0, rest_off} + CNT_ONE;
    end else begin
      if (save_ok) begin
        slot_d[tail_q] = {save_dep, save_busy};
        tail_d         = tail_q + PTR_ONE;
      end
      if (rel_ok) head_d = head_q + PTR_ONE;
      case ({save_ok, rel_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_CKPT; s++) slot_q[s] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/rename_regfile_ckpt.sv
// Architectural register file + rename table with branch checkpoints.
// Define RF_COMMIT_BYPASS_EN to forward same-cycle commits onto the read ports.
module rename_regfile_ckpt
  import rename_regfile_ckpt_pkg::*;
#(
  parameter int ROB_WIDTH    = ROB_WIDTH_DEF,
  parameter int NUM_READ     = 2,
  parameter int COMMIT_WIDTH = 1,
  parameter int CKPT_WIDTH   = 2
) (
  input  logic                             clockIn,
  input  logic                             resetIn,
  input  logic                             clearIn,
  input  logic [NUM_READ*REG_ADDR_W-1:0]   readAddr,
  output logic [NUM_READ-1:0]              readDirty,
  output logic [NUM_READ*ROB_WIDTH-1:0]    readDep,
  output logic [NUM_READ*XLEN-1:0]         readValue,
  output logic [NUM_READ*ROB_WIDTH-1:0]    robQueryDep,
  input  logic [NUM_READ-1:0]              robQueryReady,
  input  logic [NUM_READ*XLEN-1:0]         robQueryValue,
  input  logic                             renameValid,
  input  logic [REG_ADDR_W-1:0]            renameDest,
  input  logic [ROB_WIDTH-1:0]             renameRobId,
  input  logic [COMMIT_WIDTH-1:0]          commitValid,
  input  logic [COMMIT_WIDTH*REG_ADDR_W-1:0] commitDest,
  input  logic [COMMIT_WIDTH*XLEN-1:0]     commitValue,
  input  logic [COMMIT_WIDTH*ROB_WIDTH-1:0] commitRobId,
  input  logic                             ckptSave,
  output logic [CKPT_WIDTH-1:0]            ckptSaveId,
  output logic                             ckptFull,
  input  logic                             ckptRelease,
  input  logic                             ckptRestore,
  input  logic [CKPT_WIDTH-1:0]            ckptRestoreId
);
  localparam int DW = NUM_ARCH * ROB_WIDTH;

  logic [XLEN-1:0]              reg_q [NUM_ARCH];
  logic [XLEN-1:0]              reg_d [NUM_ARCH];
  logic [NUM_ARCH-1:0]          busy_q, busy_d, busy_n;
  logic [DW-1:0]                dep_q, dep_d, dep_n;
  logic [NUM_READ*REG_ADDR_W-1:0] raddr_q, raddr_d;

  logic [NUM_ARCH-1:0]          cm_wr;
  logic [XLEN-1:0]              cm_val [NUM_ARCH];
  logic [DW-1:0]                cm_id;
  logic                         restore_ok;
  logic [NUM_ARCH-1:0]          rest_busy;
  logic [DW-1:0]                rest_dep;

  // Collapse commit lanes per destination; the youngest lane overwrites.
  always_comb begin
    int d;
    d     = 0;
    cm_wr = '0;
    cm_id = '0;
    for (int r = 0; r < NUM_ARCH; r++) cm_val[r] = '0;
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      d = int'(commitDest[l*REG_ADDR_W +: REG_ADDR_W]);
      if (commitValid[l] && d != 0) begin
        cm_wr[d]                     = 1'b1;
        cm_val[d]                    = commitValue[l*XLEN +: XLEN];
        cm_id[d*ROB_WIDTH +: ROB_WIDTH] = commitRobId[l*ROB_WIDTH +: ROB_WIDTH];
      end
    end
  end

  always_comb begin
    int rd;
    rd     = int'(renameDest);
    busy_n = busy_q;
    dep_n  = dep_q;
    for (int r = 0; r < NUM_ARCH; r++) begin
      if (cm_wr[r] && dep_q[r*ROB_WIDTH +: ROB_WIDTH] == cm_id[r*ROB_WIDTH +: ROB_WIDTH])
        busy_n[r] = 1'b0;
    end
    // Rename applied after commit so a same-cycle rename keeps the register busy.
    if (renameValid && rd != 0) begin
      busy_n[rd]                       = 1'b1;
      dep_n[rd*ROB_WIDTH +: ROB_WIDTH] = renameRobId;
    end
    busy_d = busy_n;
    dep_d  = dep_n;
    if (clearIn) begin
      busy_d = '0;
      dep_d  = dep_q;
    end else if (restore_ok) begin
      busy_d = rest_busy;
      dep_d  = rest_dep;
    end
    for (int r = 0; r < NUM_ARCH; r++) reg_d[r] = cm_wr[r] ? cm_val[r] : reg_q[r];
    raddr_d = readAddr;
  end

  rf_ckpt_fifo #(
    .ROB_WIDTH  (ROB_WIDTH),
    .CKPT_WIDTH (CKPT_WIDTH)
  ) u_ckpt (
    .clk         (clockIn),
    .rst         (resetIn),
    .clr         (clearIn),
    .save_req    (ckptSave),
    .save_busy   (busy_n),
    .save_dep    (dep_n),
    .release_req (ckptRelease),
    .restore_req (ckptRestore),
    .restore_id  (ckptRestoreId),
    .commit_en   (cm_wr),
    .commit_id   (cm_id),
    .save_id     (ckptSaveId),
    .full        (ckptFull),
    .restore_ok  (restore_ok),
    .rest_busy   (rest_busy),
    .rest_dep    (rest_dep)
  );

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      for (int r = 0; r < NUM_ARCH; r++) reg_q[r] <= '0;
      busy_q  <= '0;
      dep_q   <= '0;
      raddr_q <= '0;
    end else begin
      reg_q   <= reg_d;
      busy_q  <= busy_d;
      dep_q   <= dep_d;
      raddr_q <= raddr_d;
    end
  end

  always_comb begin
    int             a;
    logic           bsy;
    logic [ROB_WIDTH-1:0] dep;
    a           = 0;
    bsy         = 1'b0;
    dep         = '0;
    readDirty   = '0;
    readDep     = '0;
    readValue   = '0;
    robQueryDep = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      a   = int'(raddr_q[p*REG_ADDR_W +: REG_ADDR_W]);
      bsy = busy_q[a];
      dep = dep_q[a*ROB_WIDTH +: ROB_WIDTH];
      readDep[p*ROB_WIDTH +: ROB_WIDTH]     = dep;
      robQueryDep[p*ROB_WIDTH +: ROB_WIDTH] = dep;
      readDirty[p]                          = bsy & ~robQueryReady[p];
      readValue[p*XLEN +: XLEN]             = bsy ? robQueryValue[p*XLEN +: XLEN] : reg_q[a];
`ifdef RF_COMMIT_BYPASS_EN
      for (int l = 0; l < COMMIT_WIDTH; l++) begin
        if (bsy && commitValid[l] &&
            int'(commitDest[l*REG_ADDR_W +: REG_ADDR_W]) == a &&
            commitRobId[l*ROB_WIDTH +: ROB_WIDTH] == dep) begin
          readValue[p*XLEN +: XLEN] = commitValue[l*XLEN +: XLEN];
          readDirty[p]              = 1'b0;
        end
      end
`else
      // Without bypass a committing value is only visible through the ROB query.
`endif
    end
  end
endmodule
